// File: rtl/map_byte_packer_if.sv
// map_byte_packer_if: UART byte stream in, packed map word out.
// master drives bytes, slave is the packer.
interface map_byte_packer_if #(
   parameter int BYTES_PER_WORD = 36
);
   logic                        rx_valid;
   logic [7:0]                  rx_byte;
   logic                        map_ena;
   logic [8*BYTES_PER_WORD-1:0] map_data;
   logic [7:0]                  word_cnt;
   logic                        frame_done;
   logic                        timeout_err;

   modport master (
      output rx_valid, rx_byte,
      input  map_ena, map_data, word_cnt,
      input  frame_done, timeout_err
   );

   modport slave (
      input  rx_valid, rx_byte,
      output map_ena, map_data, word_cnt,
      output frame_done, timeout_err
   );
endinterface

// File: rtl/map_byte_packer.sv
// map_byte_packer: packs UART bytes into feature-map words.
// Optional partial-word timeout: define MAP_PACKER_TIMEOUT_EN.
module map_byte_packer #(
   parameter int BYTES_PER_WORD  = 36,
   parameter int WORDS_PER_FRAME = 144,
   parameter int TIMEOUT_CYCLES  = 50000
) (
   input logic          clk,
   input logic          rst,
   map_byte_packer_if.slave bus
);
   localparam int W  = 8 * BYTES_PER_WORD;
   localparam int CW = $clog2(BYTES_PER_WORD + 1);

   typedef enum logic {COLLECT, EMIT} state_t;

   state_t          state;
   logic [CW-1:0]   byteCnt;
   logic [W-1:0]    asmReg;
   logic [W-1:0]    nextAsm;
   logic [W-1:0]    mapData;
   logic [7:0]      wordCnt;
   logic            mapEna;
   logic            frameDone;
   logic            lastByte;
   logic            idleHit;

   if (BYTES_PER_WORD < 2 || TIMEOUT_CYCLES < 1)
   begin : gBadParam
      $error("map_byte_packer: bad parameters");
   end

   assign nextAsm  = {asmReg[W-9:0], bus.rx_byte};
   assign lastByte = (byteCnt == CW'(BYTES_PER_WORD - 1));

`ifdef MAP_PACKER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] idleCnt;
   logic          timeoutErr;

   assign idleHit = (state == COLLECT) &&
                    (byteCnt != '0) &&
                    !bus.rx_valid &&
                    (idleCnt == TW'(TIMEOUT_CYCLES - 1));

   // Count idle clocks while a partial word is pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idleCnt    <= '0;
         timeoutErr <= 1'b0;
      end else begin
         timeoutErr <= idleHit;
         if (bus.rx_valid || idleHit ||
             state == EMIT || byteCnt == '0)
            idleCnt <= '0;
         else
            idleCnt <= idleCnt + 1'b1;
      end
   end

   assign bus.timeout_err = timeoutErr;
`else
   assign idleHit         = 1'b0;
   assign bus.timeout_err = 1'b0;
`endif

   // Collect bytes, emit a word on the last one, track frame position.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= COLLECT;
         byteCnt   <= '0;
         asmReg    <= '0;
         mapData   <= '0;
         mapEna    <= 1'b0;
         wordCnt   <= '0;
         frameDone <= 1'b0;
      end else begin
         mapEna    <= 1'b0;
         frameDone <= 1'b0;
         if (state == EMIT)
            state <= COLLECT;
         if (bus.rx_valid) begin
            asmReg <= nextAsm;
            if (lastByte) begin
               state   <= EMIT;
               byteCnt <= '0;
               mapData <= nextAsm;
               mapEna  <= 1'b1;
               if (wordCnt == 8'(WORDS_PER_FRAME - 1)) begin
                  wordCnt   <= '0;
                  frameDone <= 1'b1;
               end else begin
                  wordCnt <= wordCnt + 8'd1;
               end
            end else begin
               byteCnt <= byteCnt + 1'b1;
            end
         end else if (idleHit) begin
            byteCnt <= '0;
            asmReg  <= '0;
         end
      end
   end

   assign bus.map_ena    = mapEna;
   assign bus.map_data   = mapData;
   assign bus.word_cnt   = wordCnt;
   assign bus.frame_done = frameDone;
endmodule

// File: tb/tb_map_byte_packer.sv
// tb_map_byte_packer: directed table, corner sequences and random
// traffic checked against a byte-queue reference model.
module tb_map_byte_packer;
   localparam int BPW = 36;
   localparam int WPF = 144;
   localparam int TO  = 100;
   localparam int W   = 8 * BPW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   map_byte_packer_if #(.BYTES_PER_WORD(BPW)) bus();

   map_byte_packer #(
      .BYTES_PER_WORD(BPW),
      .WORDS_PER_FRAME(WPF),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int compared   = 0;
   int mismatched = 0;

   task automatic check(input string name,
                        input logic [W-1:0] act,
                        input logic [W-1:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: bytes queue up, every BPW of them form a word.
   logic [7:0]   q[$];
   int           framePos = 0;
   int           idle     = 0;
   bit           expEna   = 0;
   bit           expFrame = 0;
   bit           expTo    = 0;
   logic [W-1:0] expData  = '0;

   initial forever begin
      @(posedge clk);
      expEna   = 0;
      expFrame = 0;
      expTo    = 0;
      if (rst) begin
         q.delete();
         framePos = 0;
         idle     = 0;
         expData  = '0;
      end else if (bus.rx_valid) begin
         idle = 0;
         q.push_back(bus.rx_byte);
         if (q.size() == BPW) begin
            for (int i = 0; i < BPW; i++)
               expData[W-1-8*i -: 8] = q[i];
            q.delete();
            expEna   = 1;
            framePos = (framePos + 1) % WPF;
            expFrame = (framePos == 0);
         end
      end else if (q.size() > 0) begin
`ifdef MAP_PACKER_TIMEOUT_EN
         idle++;
         if (idle == TO) begin
            q.delete();
            idle  = 0;
            expTo = 1;
         end
`endif
      end
   end

   // Cycle checker plus event counters for the directed sequences.
   int cyc        = 0;
   int enaCount   = 0;
   int frameCount = 0;
   int toCount    = 0;
   int lastEnaCyc = -1;
   int minSpacing = 1000000;

   initial forever begin
      @(posedge clk);
      cyc++;
      #1;
      check("map_ena", W'(bus.map_ena), W'(expEna));
      check("frame_done", W'(bus.frame_done), W'(expFrame));
      check("timeout_err", W'(bus.timeout_err), W'(expTo));
      check("word_cnt", W'(bus.word_cnt), W'(framePos));
      check("map_data", bus.map_data, expData);
      if (bus.map_ena) begin
         enaCount++;
         if (lastEnaCyc >= 0 && cyc - lastEnaCyc < minSpacing)
            minSpacing = cyc - lastEnaCyc;
         lastEnaCyc = cyc;
      end
      if (bus.frame_done) frameCount++;
      if (bus.timeout_err) toCount++;
   end

   task automatic sendByte(input logic [7:0] b, input int gap);
      bus.rx_valid = 1'b1;
      bus.rx_byte  = b;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic doReset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst        = 1'b0;
      enaCount   = 0;
      frameCount = 0;
      toCount    = 0;
      lastEnaCyc = -1;
      minSpacing = 1000000;
      @(negedge clk);
   endtask

   function automatic logic [W-1:0] fill(input logic [7:0] b);
      logic [W-1:0] v;
      for (int i = 0; i < BPW; i++) v[8*i +: 8] = b;
      return v;
   endfunction

   typedef struct {
      int         n;
      logic [7:0] first;
      logic [7:0] step;
      int         gap;
      int         expEnas;
      logic [7:0] expHi;
      logic [7:0] expLo;
      logic [7:0] expCnt;
   } vec_t;

   vec_t vecs[5];
   logic [W-1:0] word;
   logic [7:0]   b;

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_byte  = '0;
      vecs[0] = '{36,  8'h01, 8'h01, 9, 1, 8'h01, 8'h24, 8'd1};
      vecs[1] = '{72,  8'h00, 8'h01, 0, 2, 8'h24, 8'h47, 8'd2};
      vecs[2] = '{35,  8'h10, 8'h01, 0, 0, 8'h00, 8'h00, 8'd0};
      vecs[3] = '{37,  8'h80, 8'h02, 1, 1, 8'h80, 8'hC6, 8'd1};
      vecs[4] = '{108, 8'hFF, 8'hFF, 0, 3, 8'hB7, 8'h94, 8'd3};

      @(negedge clk);
      check("reset map_data", bus.map_data, '0);
      check("reset word_cnt", W'(bus.word_cnt), '0);
      check("reset map_ena", W'(bus.map_ena), '0);

      foreach (vecs[k]) begin
         doReset();
         b = vecs[k].first;
         for (int i = 0; i < vecs[k].n; i++) begin
            sendByte(b, vecs[k].gap);
            b = b + vecs[k].step;
         end
         repeat (3) @(negedge clk);
         check($sformatf("vec%0d enas", k),
               W'(enaCount), W'(vecs[k].expEnas));
         check($sformatf("vec%0d hi", k),
               W'(bus.map_data[W-1 -: 8]), W'(vecs[k].expHi));
         check($sformatf("vec%0d lo", k),
               W'(bus.map_data[7:0]), W'(vecs[k].expLo));
         check($sformatf("vec%0d word_cnt", k),
               W'(bus.word_cnt), W'(vecs[k].expCnt));
      end

      doReset();
      for (int i = 0; i < WPF * BPW; i++) sendByte(8'hFA, 0);
      repeat (3) @(negedge clk);
      check("frame enas", W'(enaCount), W'(WPF));
      check("frame done count", W'(frameCount), W'(1));
      check("frame word_cnt", W'(bus.word_cnt), '0);
      check("frame data", bus.map_data, fill(8'hFA));
      check("frame spacing", W'(minSpacing), W'(BPW));

      doReset();
      for (int i = 0; i < 20; i++) sendByte(8'h33, 0);
      doReset();
      for (int i = 0; i < BPW; i++) sendByte(8'hAA, 1);
      repeat (3) @(negedge clk);
      check("rst enas", W'(enaCount), W'(1));
      check("rst data", bus.map_data, fill(8'hAA));
      check("rst word_cnt", W'(bus.word_cnt), W'(1));

      doReset();
      for (int i = 0; i < 10; i++) sendByte(8'h11 + 8'(i), 0);
      repeat (TO) @(negedge clk);
      for (int i = 0; i < BPW; i++) sendByte(8'h55, 0);
      repeat (3) @(negedge clk);
`ifdef MAP_PACKER_TIMEOUT_EN
      word = fill(8'h55);
      check("to count", W'(toCount), W'(1));
`else
      word = fill(8'h55);
      for (int i = 0; i < 10; i++)
         word[W-1-8*i -: 8] = 8'h11 + 8'(i);
      check("to count", W'(toCount), '0);
`endif
      check("to enas", W'(enaCount), W'(1));
      check("to data", bus.map_data, word);

`ifdef MAP_PACKER_TIMEOUT_EN
      doReset();
      for (int i = 0; i < 10; i++) sendByte(8'h22, 0);
      repeat (TO - 1) @(negedge clk);
      for (int i = 0; i < BPW - 10; i++) sendByte(8'h66, 0);
      repeat (3) @(negedge clk);
      check("to race count", W'(toCount), '0);
      check("to race enas", W'(enaCount), W'(1));
`endif

      doReset();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) doReset();
         if ($urandom_range(0, 99) == 0)
            repeat ($urandom_range(90, 130)) @(negedge clk);
         sendByte(8'($urandom), $urandom_range(0, 2));
      end
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end
endmodule

// File: doc/map_byte_packer.md
MAP_BYTE_PACKER -- requirements
Module: map_byte_packer

Interface
REQ-001 Parameter BYTES_PER_WORD, default 36: bytes per packed feature-map word (6*6*8 = 288 bits).
REQ-002 Parameter WORDS_PER_FRAME, default 144: map words per input image.
REQ-003 Parameter TIMEOUT_CYCLES, default 50000: idle clocks before a partial word is discarded.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_byte holds a received UART byte.
REQ-007 rx_byte  input  8  received byte.
REQ-008 map_ena  output  1  one-cycle strobe; map_data holds a complete word.
REQ-009 map_data  output  8*BYTES_PER_WORD  packed word, held stable between map_ena strobes.
REQ-010 word_cnt  output  8  words emitted in the current frame, 0..WORDS_PER_FRAME-1.
REQ-011 frame_done  output  1  one-cycle strobe on the last word of a frame.
REQ-012 timeout_err  output  1  one-cycle strobe when a partial word is discarded.

Function
REQ-013 The block SHALL use two states: COLLECT (byte_cnt 0..BYTES_PER_WORD-1) and EMIT (one cycle).
REQ-014 In COLLECT, each rx_valid cycle SHALL shift the assembly register left 8 bits, insert rx_byte at [7:0] and increment byte_cnt, so the first byte ends up at [8*BYTES_PER_WORD-1 -: 8].
REQ-015 The byte that makes byte_cnt reach BYTES_PER_WORD SHALL move the FSM to EMIT, clear byte_cnt and copy the assembly register to map_data.
REQ-016 In EMIT, map_ena SHALL be 1 for exactly one cycle: latency 1 clock after the final rx_valid. The FSM SHALL then return to COLLECT.
REQ-017 An rx_valid arriving during EMIT SHALL be accepted as byte 0 of the next word. No byte is dropped, and map_data still shows the just-completed word.
REQ-018 word_cnt SHALL increment on each map_ena. The increment SHALL be modulo WORDS_PER_FRAME.
REQ-019 frame_done SHALL pulse in the same cycle as the map_ena that carries word WORDS_PER_FRAME-1, and word_cnt SHALL wrap to 0 on that edge.
REQ-020 The minimum spacing between map_ena strobes SHALL be BYTES_PER_WORD cycles. This always leaves the downstream controller its 3-cycle capture/write window.
REQ-021 rx_valid with no active word assembly SHALL never produce map_ena. Only a full BYTES_PER_WORD count emits a word.

Reset
REQ-022 While rst=1, outputs SHALL be: map_ena=0, map_data=0, word_cnt=0, frame_done=0, timeout_err=0. Internal state SHALL be: FSM in COLLECT, byte_cnt=0, assembly register=0, idle counter=0.
REQ-023 A reset asserted mid-word or mid-frame SHALL discard all partial data. The first byte after release SHALL be byte 0 of word 0.

Configuration
REQ-024 With macro MAP_PACKER_TIMEOUT_EN defined, an idle counter SHALL count clocks in COLLECT with byte_cnt>0 and no rx_valid, and SHALL clear on every rx_valid.
REQ-025 When that counter reaches TIMEOUT_CYCLES, the block SHALL on the next edge:
- clear byte_cnt and the assembly register;
- pulse timeout_err for one cycle;
- leave word_cnt and map_data unchanged.
REQ-026 An rx_valid in the same cycle the count reaches TIMEOUT_CYCLES SHALL take priority: the byte is accepted and no timeout occurs.
REQ-027 Without MAP_PACKER_TIMEOUT_EN, the idle counter SHALL not exist, timeout_err SHALL be tied to 0, and a partial word SHALL wait indefinitely.

Verification
REQ-028 Reset, then 36 bytes 0x01..0x24 one per 10 clocks -> map_ena high for one cycle, 1 clock after the 36th byte. map_data[287:280]=0x01, map_data[7:0]=0x24, word_cnt=1.
REQ-029 Back-to-back rx_valid for 72 cycles, bytes 0x00..0x47 -> two map_ena strobes 36 cycles apart. The second word starts with 0x24, proving the byte accepted during EMIT is kept.
REQ-030 144 words of 0xFA bytes -> frame_done coincides with the 144th map_ena, word_cnt returns to 0, and exactly one frame_done occurs.
REQ-031 20 bytes, rst pulse, then 36 bytes 0xAA -> a single map_ena with all bytes 0xAA and word_cnt=1.
REQ-032 With MAP_PACKER_TIMEOUT_EN and TIMEOUT_CYCLES=100: send 10 bytes, idle 100 clocks, then send 36 bytes 0x55 -> one timeout_err pulse, then one map_ena with all bytes 0x55. Without the macro, the same stimulus gives timeout_err=0 and a word whose first 10 bytes are the early ones.
